// File: rtl/cal_hu_deadlock_report_collector.sv
// Deadlock report collector for the CAL_Hu dataflow monitors.
// Each monitor's 'block' flag must stay high for CONFIRM_CYCLES consecutive
// cycles before it is confirmed. Confirmed, not-yet-reported monitors are
// reported one at a time, lowest index first, over a valid/ready channel.
// Sticky deadlock / lost-report status bits are held until 'clear' pulses.
module cal_hu_deadlock_report_collector #(
    parameter int NUM_MON        = 4,
    parameter int CONFIRM_CYCLES = 16,
    parameter int CNT_W          = 16,
    parameter int ID_W           = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_MON-1:0] block_in,
    input  logic               clear,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [ID_W-1:0]    rpt_mon_id,
    output logic [CNT_W-1:0]   rpt_timestamp,
    output logic [NUM_MON-1:0] rpt_block_vec,
    output logic               deadlock_flag,
    output logic               rpt_lost
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CONFIRM_MAX = CNT_W'(CONFIRM_CYCLES);

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                cycle_cnt_q, cycle_cnt_d;
    logic [NUM_MON-1:0][CNT_W-1:0]   confirm_cnt_q, confirm_cnt_d;
    logic [NUM_MON-1:0]              reported_q, reported_d;
    logic [NUM_MON-1:0]              confirmed;
    logic [NUM_MON-1:0]              pending;
    logic [NUM_MON-1:0]              lost_evt;
    logic                            rpt_valid_q, rpt_valid_d;
    logic [ID_W-1:0]                 rpt_mon_id_q, rpt_mon_id_d;
    logic [CNT_W-1:0]                rpt_timestamp_q, rpt_timestamp_d;
    logic [NUM_MON-1:0]              rpt_block_vec_q, rpt_block_vec_d;
    logic                            deadlock_flag_q, deadlock_flag_d;
    logic                            rpt_lost_q, rpt_lost_d;
    logic                            handshake;
    logic [ID_W-1:0]                 sel_id;

    assign handshake = rpt_valid_q & rpt_ready;
    assign pending   = confirmed & ~reported_q;

    // Per-monitor confirm counter, reported bit and lost-report detection.
    // The monitor currently being offered in SEND is excluded from the lost
    // check because its report is already committed to the channel.
    for (genvar gi = 0; gi < NUM_MON; gi++) begin : g_mon
        assign confirmed[gi] = (confirm_cnt_q[gi] == CONFIRM_MAX);

        assign confirm_cnt_d[gi] = !block_in[gi] ? '0 :
                                   confirmed[gi] ? confirm_cnt_q[gi] :
                                                   confirm_cnt_q[gi] + CNT_W'(1);

        assign lost_evt[gi] = !block_in[gi] && confirmed[gi] && !reported_q[gi] &&
                              !((state_q == SEND) && (rpt_mon_id_q == ID_W'(gi)));

        // Clearing (block dropped or software clear) wins over a handshake set.
        assign reported_d[gi] = (!block_in[gi] || clear) ? 1'b0 :
                                (reported_q[gi] ||
                                 (handshake && (rpt_mon_id_q == ID_W'(gi))));
    end

    // Lowest-index pending monitor wins selection.
    always_comb begin
        sel_id = '0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_id = ID_W'(i);
            end
        end
    end

    // Next-state for the report FSM, payload, timestamp counter and sticky flags.
    always_comb begin
        state_d         = state_q;
        rpt_valid_d     = rpt_valid_q;
        rpt_mon_id_d    = rpt_mon_id_q;
        rpt_timestamp_d = rpt_timestamp_q;
        rpt_block_vec_d = rpt_block_vec_q;
        cycle_cnt_d     = cycle_cnt_q + CNT_W'(1);
        deadlock_flag_d = clear ? 1'b0 : (deadlock_flag_q | handshake);
        rpt_lost_d      = clear ? 1'b0 : (rpt_lost_q | (|lost_evt));

        case (state_q)
            IDLE: begin
                if (|pending) begin
                    state_d         = SEND;
                    rpt_valid_d     = 1'b1;
                    rpt_mon_id_d    = sel_id;
                    rpt_timestamp_d = cycle_cnt_q;
                    rpt_block_vec_d = block_in;
                end
            end
            SEND: begin
                // Payload held untouched; only a handshake ends the offer.
                if (handshake) begin
                    state_d     = IDLE;
                    rpt_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                rpt_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q         <= IDLE;
            cycle_cnt_q     <= '0;
            confirm_cnt_q   <= '0;
            reported_q      <= '0;
            rpt_valid_q     <= 1'b0;
            rpt_mon_id_q    <= '0;
            rpt_timestamp_q <= '0;
            rpt_block_vec_q <= '0;
            deadlock_flag_q <= 1'b0;
            rpt_lost_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            cycle_cnt_q     <= cycle_cnt_d;
            confirm_cnt_q   <= confirm_cnt_d;
            reported_q      <= reported_d;
            rpt_valid_q     <= rpt_valid_d;
            rpt_mon_id_q    <= rpt_mon_id_d;
            rpt_timestamp_q <= rpt_timestamp_d;
            rpt_block_vec_q <= rpt_block_vec_d;
            deadlock_flag_q <= deadlock_flag_d;
            rpt_lost_q      <= rpt_lost_d;
        end
    end

    assign rpt_valid     = rpt_valid_q;
    assign rpt_mon_id    = rpt_mon_id_q;
    assign rpt_timestamp = rpt_timestamp_q;
    assign rpt_block_vec = rpt_block_vec_q;
    assign deadlock_flag = deadlock_flag_q;
    assign rpt_lost      = rpt_lost_q;

endmodule
